// File: rtl/sdram_stream_scheduler_pkg.sv
// Shared definitions for the SDRAM stream scheduler: controller command
// encodings, FSM state type and small sizing helpers.
package sdram_stream_scheduler_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  localparam int unsigned READ_BURST_LENGTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Width needed to index n channels; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_stream_scheduler_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found when
// scanning upward from the channel after last_i, wrapping at NUM_CHAN.
module rr_arbiter
  import sdram_stream_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 2,
  parameter int unsigned PTR_W    = idx_width(NUM_CHAN)
) (
  input  logic [NUM_CHAN-1:0] req_i,
  input  logic [PTR_W-1:0]    last_i,
  output logic [NUM_CHAN-1:0] grant_o
);

  // Scan priority order last_i+1, last_i+2, ... and keep only the first hit.
  always_comb begin : p_scan
    logic        found;
    int unsigned idx;
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_CHAN; k++) begin
      idx = (32'(last_i) + k) % NUM_CHAN;
      for (int unsigned c = 0; c < NUM_CHAN; c++) begin
        if (!found && (c == idx) && req_i[c]) begin
          grant_o[c] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_stream_scheduler.sv
// SDRAM stream scheduler: arbitrates NUM_CHAN read-burst / write-back-in-place
// streams onto one SDRAM controller command port. Each channel walks its own
// region; the region pointer advances only when a write-back burst completes.
module sdram_stream_scheduler
  import sdram_stream_scheduler_pkg::*;
#(
  parameter int unsigned                NUM_CHAN   = 2,
  parameter int unsigned                ADDR_W     = 22,
  parameter int unsigned                DATA_W     = 32,
  parameter int unsigned                CNT_W      = 8,
  parameter logic [NUM_CHAN*ADDR_W-1:0] CHAN_BASE  = {22'h20000, 22'h0},
  parameter logic [NUM_CHAN*ADDR_W-1:0] CHAN_LEN   = {22'd768000, 22'd96000},
  parameter logic [NUM_CHAN*CNT_W-1:0]  CHAN_BURST = {8'd64, 8'd8}
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic [NUM_CHAN-1:0]        i_Chan_En,
  input  logic [NUM_CHAN-1:0]        i_Rd_Empty,
  input  logic [NUM_CHAN-1:0]        i_Wb_Empty,
  input  logic [NUM_CHAN-1:0]        i_Wb_Full,
  input  logic [NUM_CHAN*DATA_W-1:0] i_Wb_Data,
  input  logic                       i_Data_Read_Valid,
  input  logic                       i_Data_Write_Done,
  input  logic                       i_SDRAM_Requested,
  output logic                       o_SDRAM_Yield,
  output logic [1:0]                 o_Command,
  output logic [ADDR_W-1:0]          o_Data_Address,
  output logic [DATA_W-1:0]          o_Data_Write,
  output logic [NUM_CHAN-1:0]        o_Rd_Wrreq,
  output logic [NUM_CHAN-1:0]        o_Wb_Rdreq,
  output logic [NUM_CHAN-1:0]        o_Region_Done
);

  localparam int unsigned CHW   = idx_width(NUM_CHAN);
  localparam int unsigned SUM_W = ADDR_W + 1;

  // Per-channel configuration unpacked from the packed parameters.
  logic [ADDR_W-1:0] base_w   [NUM_CHAN];
  logic [ADDR_W-1:0] len_w    [NUM_CHAN];
  logic [CNT_W-1:0]  bfld_w   [NUM_CHAN];
  logic [SUM_W-1:0]  bwords_w [NUM_CHAN];

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_cfg
    assign base_w[g] = CHAN_BASE[g*ADDR_W +: ADDR_W];
    assign len_w[g]  = CHAN_LEN[g*ADDR_W +: ADDR_W];
    assign bfld_w[g] = CHAN_BURST[g*CNT_W +: CNT_W];
    // A zero burst field stands for the full 2^CNT_W words, matching the
    // countdown which then starts at all-ones.
    assign bwords_w[g] = (bfld_w[g] == '0) ? (SUM_W'(1) << CNT_W)
                                           : SUM_W'(bfld_w[g]);
  end

  state_e            st_q,   st_d;
  logic [CHW-1:0]    chan_q, chan_d;
  logic [CHW-1:0]    last_q, last_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] off_q  [NUM_CHAN];
  logic [ADDR_W-1:0] off_d  [NUM_CHAN];
  logic [NUM_CHAN-1:0] done_q, done_d;

  logic [NUM_CHAN-1:0] flush_req, fill_req, req, gnt;
  logic [CHW-1:0]      gnt_idx;
  logic [SUM_W-1:0]    off_sum;
  logic                off_wrap;

  assign flush_req = i_Chan_En & i_Wb_Full;
  assign fill_req  = i_Chan_En & i_Rd_Empty & i_Wb_Empty;
  assign req       = flush_req | fill_req;

  rr_arbiter #(
    .NUM_CHAN (NUM_CHAN),
    .PTR_W    (CHW)
  ) u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (gnt)
  );

  // Encode the one-hot grant into a channel index.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      if (gnt[c]) gnt_idx = CHW'(c);
    end
  end

  // Exact wrap: compare the one-bit-wider sum against the region length.
  assign off_sum  = SUM_W'(off_q[chan_q]) + bwords_w[chan_q];
  assign off_wrap = (off_sum == SUM_W'(len_w[chan_q]));

  assign o_SDRAM_Yield  = i_SDRAM_Requested && (st_q == ST_IDLE);
  assign o_Data_Address = addr_q;
  assign o_Data_Write   = i_Wb_Data[chan_q*DATA_W +: DATA_W];
  assign o_Region_Done  = done_q;

  // Command output is a pure decode of the current state.
  always_comb begin
    case (st_q)
      ST_READ:  o_Command = CMD_READ;
      ST_WRITE: o_Command = CMD_WRITE;
      default:  o_Command = CMD_IDLE;
    endcase
  end

  // Next-state logic: grant in IDLE, count beats in READ/WRITE, advance the
  // region pointer only on the last write-back beat.
  always_comb begin
    st_d       = st_q;
    chan_d     = chan_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    off_d      = off_q;
    done_d     = '0;
    o_Rd_Wrreq = '0;
    o_Wb_Rdreq = '0;
    case (st_q)
      ST_IDLE: begin
        if (!i_SDRAM_Requested && (|req)) begin
          chan_d = gnt_idx;
          last_d = gnt_idx;
          cnt_d  = bfld_w[gnt_idx] - CNT_W'(1);
          addr_d = base_w[gnt_idx] + off_q[gnt_idx];
          st_d   = flush_req[gnt_idx] ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (i_Data_Read_Valid) begin
          o_Rd_Wrreq[chan_q] = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (cnt_q == '0) begin
            st_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        if (i_Data_Write_Done) begin
          o_Wb_Rdreq[chan_q] = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (cnt_q == '0) begin
            st_d = ST_IDLE;
            if (off_wrap) begin
              off_d[chan_q]  = '0;
              done_d[chan_q] = 1'b1;
            end else begin
              off_d[chan_q] = off_sum[ADDR_W-1:0];
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      st_q   <= ST_IDLE;
      chan_q <= '0;
      last_q <= CHW'(NUM_CHAN - 1);
      cnt_q  <= '0;
      addr_q <= '0;
      done_q <= '0;
      for (int unsigned c = 0; c < NUM_CHAN; c++) off_q[c] <= '0;
    end else begin
      st_q   <= st_d;
      chan_q <= chan_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      done_q <= done_d;
      for (int unsigned c = 0; c < NUM_CHAN; c++) off_q[c] <= off_d[c];
    end
  end

endmodule

// File: tb/tb_sdram_stream_scheduler.sv
// Self-checking bench for sdram_stream_scheduler: a transaction-level model
// checked every cycle, plus directed bursts with hand-computed addresses.
`timescale 1ns/1ps
module tb_sdram_stream_scheduler;
  import sdram_stream_scheduler_pkg::*;

  localparam int unsigned NC = 2;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam logic [NC*AW-1:0] BASE = {22'h20000, 22'h0};
  localparam logic [NC*AW-1:0] LEN  = {22'd256, 22'd32};
  localparam logic [NC*CW-1:0] BUR  = {8'd64, 8'd8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NC-1:0] en, rd_empty, wb_empty, wb_full;
  logic [NC*DW-1:0] wb_data;
  logic          valid, wdone, sreq;
  logic          o_SDRAM_Yield;
  logic [1:0]    o_Command;
  logic [AW-1:0] o_Data_Address;
  logic [DW-1:0] o_Data_Write;
  logic [NC-1:0] o_Rd_Wrreq, o_Wb_Rdreq, o_Region_Done;

  sdram_stream_scheduler #(
    .NUM_CHAN   (NC),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .CNT_W      (CW),
    .CHAN_BASE  (BASE),
    .CHAN_LEN   (LEN),
    .CHAN_BURST (BUR)
  ) dut (
    .i_Clk             (clk),
    .i_Rst_n           (rst_n),
    .i_Chan_En         (en),
    .i_Rd_Empty        (rd_empty),
    .i_Wb_Empty        (wb_empty),
    .i_Wb_Full         (wb_full),
    .i_Wb_Data         (wb_data),
    .i_Data_Read_Valid (valid),
    .i_Data_Write_Done (wdone),
    .i_SDRAM_Requested (sreq),
    .o_SDRAM_Yield     (o_SDRAM_Yield),
    .o_Command         (o_Command),
    .o_Data_Address    (o_Data_Address),
    .o_Data_Write      (o_Data_Write),
    .o_Rd_Wrreq        (o_Rd_Wrreq),
    .o_Wb_Rdreq        (o_Wb_Rdreq),
    .o_Region_Done     (o_Region_Done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC-1:0] onehot(input int c);
    return NC'(1) << c;
  endfunction

  // Region model: what each channel's stream must be doing.
  logic [AW-1:0] m_base [NC] = '{22'h0, 22'h20000};
  int unsigned   m_len  [NC] = '{32, 256};
  int unsigned   m_bur  [NC] = '{8, 64};
  int unsigned   m_off  [NC];
  bit            m_busy, m_wr, armed;
  int unsigned   m_chan, m_beat, m_last;
  logic [NC-1:0] m_done;

  initial begin : model_cmp
    logic [NC-1:0] oh;
    int unsigned   c;
    m_busy = 1'b0; m_wr = 1'b0; armed = 1'b0;
    m_chan = 0; m_beat = 0; m_last = NC - 1; m_done = '0;
    foreach (m_off[i]) m_off[i] = 0;
    forever begin
      @(negedge clk);
      oh = m_busy ? onehot(int'(m_chan)) : '0;
      if (armed) begin
        check("m_cmd", o_Command, !m_busy ? CMD_IDLE : (m_wr ? CMD_WRITE : CMD_READ));
        check("m_yield", o_SDRAM_Yield, sreq && !m_busy);
        check("m_rd_wrreq", o_Rd_Wrreq, (m_busy && !m_wr && valid) ? oh : '0);
        check("m_wb_rdreq", o_Wb_Rdreq, (m_busy && m_wr && wdone) ? oh : '0);
        check("m_region_done", o_Region_Done, m_done);
        if (m_busy)
          check("m_addr", o_Data_Address, m_base[m_chan] + AW'(m_off[m_chan] + m_beat));
        if (m_busy && m_wr)
          check("m_wdata", o_Data_Write, wb_data[m_chan*DW +: DW]);
      end
      m_done = '0;
      if (!rst_n) begin
        m_busy = 1'b0;
        m_last = NC - 1;
        foreach (m_off[i]) m_off[i] = 0;
        armed = 1'b1;
      end else if (!m_busy) begin
        if (!sreq) begin
          for (int k = 1; k <= NC; k++) begin
            c = (m_last + k) % NC;
            if (!m_busy && en[c] && (wb_full[c] || (rd_empty[c] && wb_empty[c]))) begin
              m_busy = 1'b1; m_wr = wb_full[c]; m_chan = c; m_last = c; m_beat = 0;
            end
          end
        end
      end else if (m_wr ? wdone : valid) begin
        m_beat++;
        if (m_beat == m_bur[m_chan]) begin
          m_busy = 1'b0;
          if (m_wr) begin
            m_off[m_chan] += m_bur[m_chan];
            if (m_off[m_chan] == m_len[m_chan]) begin
              m_off[m_chan] = 0;
              m_done[m_chan] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant, then drive n beats checking literal addresses.
  task automatic burst(input int c, input bit wr, input int n, input logic [AW-1:0] start,
                       input bit gaps, input bit clr_req, input int drop_at);
    int w;
    w = 0;
    while (o_Command == CMD_IDLE && w < 16) begin
      tick();
      w++;
    end
    check("burst_cmd", o_Command, wr ? CMD_WRITE : CMD_READ);
    if (clr_req) begin
      rd_empty[c] = 1'b0; wb_empty[c] = 1'b0; wb_full[c] = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 2 == 1)) begin
        valid = wr; wdone = !wr;
        tick();
      end
      if (k == drop_at) en[c] = 1'b0;
      valid = !wr; wdone = wr;
      wb_data[c*DW +: DW] = 32'hC0DE_0000 ^ (k << 8) ^ c;
      #1;
      check("burst_addr", o_Data_Address, start + AW'(k));
      check("burst_strobe", wr ? o_Wb_Rdreq : o_Rd_Wrreq, onehot(c));
      if (wr) check("burst_wdata", o_Data_Write, wb_data[c*DW +: DW]);
      tick();
    end
    valid = 1'b0; wdone = 1'b0;
    check("burst_end", o_Command, CMD_IDLE);
  endtask

  initial begin : stim
    rst_n = 1'b0; en = '0; rd_empty = '0; wb_empty = '0; wb_full = '0;
    wb_data = {32'h1111_1111, 32'h2222_2222};
    valid = 1'b0; wdone = 1'b0; sreq = 1'b0;
    repeat (3) tick();
    check("rst_cmd", o_Command, CMD_IDLE);
    check("rst_addr", o_Data_Address, 0);
    check("rst_done", o_Region_Done, 0);
    check("rst_strobes", {o_Rd_Wrreq, o_Wb_Rdreq}, 0);
    rst_n = 1'b1; en = 2'b11;
    tick();

    // ch0 fill, then flush, then a gapped fill at the advanced offset
    rd_empty[0] = 1'b1; wb_empty[0] = 1'b1;
    burst(0, 1'b0, 8, 22'h000000, 1'b0, 1'b1, -1);
    wb_full[0] = 1'b1;
    burst(0, 1'b1, 8, 22'h000000, 1'b0, 1'b1, -1);
    rd_empty[0] = 1'b1; wb_empty[0] = 1'b1;
    burst(0, 1'b0, 8, 22'h000008, 1'b1, 1'b1, -1);

    // both flushing: last grant was ch0, so ch1 then ch0 alternate
    wb_full = 2'b11;
    burst(1, 1'b1, 64, 22'h020000, 1'b0, 1'b0, -1);
    burst(0, 1'b1, 8, 22'h000008, 1'b1, 1'b0, -1);
    burst(1, 1'b1, 64, 22'h020040, 1'b0, 1'b0, -1);
    wb_full[1] = 1'b0;
    burst(0, 1'b1, 8, 22'h000010, 1'b0, 1'b1, -1);

    // ch0 last burst of its 32-word region wraps
    wb_full[0] = 1'b1;
    burst(0, 1'b1, 8, 22'h000018, 1'b0, 1'b1, -1);
    check("wrap0_pulse", o_Region_Done, 2'b01);
    tick();
    check("wrap0_clear", o_Region_Done, 2'b00);
    wb_full[1] = 1'b1;
    burst(1, 1'b1, 64, 22'h020080, 1'b0, 1'b0, -1);
    burst(1, 1'b1, 64, 22'h0200C0, 1'b0, 1'b1, -1);
    check("wrap1_pulse", o_Region_Done, 2'b10);
    tick();
    check("wrap1_clear", o_Region_Done, 2'b00);
    rd_empty[0] = 1'b1; wb_empty[0] = 1'b1;
    burst(0, 1'b0, 8, 22'h000000, 1'b0, 1'b1, -1);

    // yield in IDLE blocks grants; raised mid-burst it waits for IDLE
    sreq = 1'b1; rd_empty[0] = 1'b1; wb_empty[0] = 1'b1;
    #1;
    check("yield_idle", o_SDRAM_Yield, 1'b1);
    repeat (3) begin
      tick();
      check("yield_nogrant", o_Command, CMD_IDLE);
    end
    sreq = 1'b0;
    tick();
    check("yield_grant", o_Command, CMD_READ);
    sreq = 1'b1;
    burst(0, 1'b0, 8, 22'h000000, 1'b0, 1'b0, -1);
    check("yield_after", o_SDRAM_Yield, 1'b1);
    repeat (2) begin
      tick();
      check("yield_hold", o_Command, CMD_IDLE);
    end
    sreq = 1'b0; rd_empty[0] = 1'b0; wb_empty[0] = 1'b0;
    tick();

    // reset on the 4th write beat drops the burst
    wb_full[0] = 1'b1;
    tick();
    check("rstw_cmd", o_Command, CMD_WRITE);
    wb_full[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wdone = 1'b1;
      #1;
      check("rstw_addr", o_Data_Address, AW'(k));
      tick();
    end
    wdone = 1'b1; rst_n = 1'b0;
    tick();
    check("rstw_idle", o_Command, CMD_IDLE);
    check("rstw_addr0", o_Data_Address, 0);
    wdone = 1'b0; rst_n = 1'b1;
    tick();
    wb_full[0] = 1'b1;
    burst(0, 1'b1, 8, 22'h000000, 1'b0, 1'b1, -1);

    // disabled channel is never granted; disabling mid-burst does not abort
    en = 2'b01; rd_empty[1] = 1'b1; wb_empty[1] = 1'b1;
    repeat (6) begin
      tick();
      check("dis_nogrant", o_Command, CMD_IDLE);
    end
    en = 2'b11;
    burst(1, 1'b0, 64, 22'h020000, 1'b0, 1'b1, 10);
    en = 2'b11;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
